// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit in front of the data memory.
// Accepts one request from execute, checks alignment, drives an 8-byte-wide
// memory port for ACCESS_LAT cycles, extends load data and returns a tagged
// response to writeback.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  request handshake; in_addr, in_wen, in_size, in_unsigned,
//                   in_wdata, in_rd carry the request
//   out_valid/ready response handshake; out_rdata, out_rd, out_misalign
//   mem_addr/ce/we/wdata/wmask  memory port (combinational from state)
//   mem_rdata       combinational read data from memory
//
// ACCESS_LAT must lie in 1..15.
module lsu_ctrl #(
   parameter int unsigned ACCESS_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_addr,
   input  logic        in_wen,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [63:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic [4:0]  out_rd,
   output logic        out_misalign,
   output logic [63:0] mem_addr,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [63:0] mem_rdata
);

   localparam int unsigned AW    = 64;
   localparam int unsigned DW    = 64;
   localparam int unsigned MW    = 8;
   localparam int unsigned TW    = 5;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // Request registers
   logic [AW-1:0] req_addr, req_addr_nxt;
   logic          req_wen, req_wen_nxt;
   logic [1:0]    req_size, req_size_nxt;
   logic          req_uns, req_uns_nxt;
   logic [DW-1:0] req_wdata, req_wdata_nxt;

   // Next values of the registered response outputs
   logic          out_valid_nxt;
   logic [DW-1:0] out_rdata_nxt;
   logic [TW-1:0] out_rd_nxt;
   logic          out_misalign_nxt;

   logic          in_misalign;
   logic [2:0]    off;
   logic [MW-1:0] size_mask;
   logic [DW-1:0] rd_shifted;
   logic [DW-1:0] load_ext;

   assign in_ready = (state == IDLE) && !rst;
   assign off      = req_addr[2:0];

   // Alignment check on the incoming request
   always_comb begin
      in_misalign = 1'b0;
      case (in_size)
         2'd0:    in_misalign = 1'b0;
         2'd1:    in_misalign = in_addr[0];
         2'd2:    in_misalign = |in_addr[1:0];
         default: in_misalign = |in_addr[2:0];
      endcase
   end

   // Byte-lane mask for the access size, before lane shifting
   always_comb begin
      size_mask = 8'h00;
      case (req_size)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   end

   // Load data: move the addressed lane to bit 0, then sign/zero-extend
   always_comb begin
      rd_shifted = mem_rdata >> {off, 3'b000};
      load_ext   = '0;
      case (req_size)
         2'd0:    load_ext = {{56{~req_uns & rd_shifted[7]}},  rd_shifted[7:0]};
         2'd1:    load_ext = {{48{~req_uns & rd_shifted[15]}}, rd_shifted[15:0]};
         2'd2:    load_ext = {{32{~req_uns & rd_shifted[31]}}, rd_shifted[31:0]};
         default: load_ext = rd_shifted;
      endcase
   end

   // Memory port; stores strobe only on the final access cycle so an
   // interrupted store never reaches memory
   always_comb begin
      mem_addr  = '0;
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      mem_wmask = '0;
      if (state == ACCESS) begin
         mem_addr  = {req_addr[AW-1:3], 3'b000};
         mem_wdata = req_wdata << {off, 3'b000};
         mem_wmask = size_mask << off;
         if (req_wen) begin
            mem_ce = (cnt == '0);
            mem_we = (cnt == '0);
         end else begin
            mem_ce = 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         req_addr     <= '0;
         req_wen      <= 1'b0;
         req_size     <= '0;
         req_uns      <= 1'b0;
         req_wdata    <= '0;
         out_valid    <= 1'b0;
         out_rdata    <= '0;
         out_rd       <= '0;
         out_misalign <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         req_addr     <= req_addr_nxt;
         req_wen      <= req_wen_nxt;
         req_size     <= req_size_nxt;
         req_uns      <= req_uns_nxt;
         req_wdata    <= req_wdata_nxt;
         out_valid    <= out_valid_nxt;
         out_rdata    <= out_rdata_nxt;
         out_rd       <= out_rd_nxt;
         out_misalign <= out_misalign_nxt;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      req_addr_nxt     = req_addr;
      req_wen_nxt      = req_wen;
      req_size_nxt     = req_size;
      req_uns_nxt      = req_uns;
      req_wdata_nxt    = req_wdata;
      out_valid_nxt    = out_valid;
      out_rdata_nxt    = out_rdata;
      out_rd_nxt       = out_rd;
      out_misalign_nxt = out_misalign;

      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               req_addr_nxt  = in_addr;
               req_wen_nxt   = in_wen;
               req_size_nxt  = in_size;
               req_uns_nxt   = in_unsigned;
               req_wdata_nxt = in_wdata;
               out_rd_nxt    = in_rd;
               if (in_misalign) begin
                  // Fault goes straight to the response, memory untouched
                  state_nxt        = RESP;
                  out_valid_nxt    = 1'b1;
                  out_misalign_nxt = 1'b1;
                  out_rdata_nxt    = '0;
               end else begin
                  state_nxt = ACCESS;
                  cnt_nxt   = CNT_W'(ACCESS_LAT - 1);
               end
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               state_nxt        = RESP;
               out_valid_nxt    = 1'b1;
               out_misalign_nxt = 1'b0;
               out_rdata_nxt    = req_wen ? '0 : load_ext;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RESP: begin
            if (out_ready) begin
               state_nxt     = IDLE;
               out_valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: three instances (ACCESS_LAT = 1, 3, 4) share the
// request data bus; each has its own valid/ready/reset. Responses are checked
// by a scoreboard queue filled at issue time and drained by a monitor.
module tb_lsu_ctrl;

   logic        clk;
   logic [2:0]  rst_v;
   logic [2:0]  in_valid_v;
   logic [2:0]  in_ready_v;
   logic [63:0] in_addr;
   logic        in_wen;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [63:0] in_wdata;
   logic [4:0]  in_rd;
   logic [2:0]  out_valid_v;
   logic [2:0]  out_ready_v;
   logic [63:0] out_rdata_v [3];
   logic [4:0]  out_rd_v [3];
   logic [2:0]  out_misalign_v;
   logic [63:0] mem_addr_v [3];
   logic [2:0]  mem_ce_v;
   logic [2:0]  mem_we_v;
   logic [63:0] mem_wdata_v [3];
   logic [7:0]  mem_wmask_v [3];
   logic [63:0] mem_rdata;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      lsu_ctrl #(.ACCESS_LAT(LAT)) u_dut (
         .clk          (clk),
         .rst          (rst_v[g]),
         .in_valid     (in_valid_v[g]),
         .in_ready     (in_ready_v[g]),
         .in_addr      (in_addr),
         .in_wen       (in_wen),
         .in_size      (in_size),
         .in_unsigned  (in_unsigned),
         .in_wdata     (in_wdata),
         .in_rd        (in_rd),
         .out_valid    (out_valid_v[g]),
         .out_ready    (out_ready_v[g]),
         .out_rdata    (out_rdata_v[g]),
         .out_rd       (out_rd_v[g]),
         .out_misalign (out_misalign_v[g]),
         .mem_addr     (mem_addr_v[g]),
         .mem_ce       (mem_ce_v[g]),
         .mem_we       (mem_we_v[g]),
         .mem_wdata    (mem_wdata_v[g]),
         .mem_wmask    (mem_wmask_v[g]),
         .mem_rdata    (mem_rdata)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          inst;
      logic [63:0] rdata;
      logic [4:0]  rd;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard whenever a response is taken
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (out_valid_v[k] && out_ready_v[k]) begin
            if (sb.size() == 0) begin
               chk("unexpected_resp", 64'(k), 64'hFFFF);
            end else begin
               e = sb.pop_front();
               chk("resp_inst", 64'(k), 64'(e.inst));
               chk("resp_rdata", out_rdata_v[k], e.rdata);
               chk("resp_rd", 64'(out_rd_v[k]), 64'(e.rd));
               chk("resp_misalign", 64'(out_misalign_v[k]), 64'(e.mis));
            end
         end
      end
   end

   task automatic drive(input int k, input logic [63:0] addr, input logic wen,
                        input logic [1:0] size, input logic uns,
                        input logic [63:0] wdata, input logic [4:0] rd);
      in_addr       = addr;
      in_wen        = wen;
      in_size       = size;
      in_unsigned   = uns;
      in_wdata      = wdata;
      in_rd         = rd;
      in_valid_v[k] = 1'b1;
   endtask

   task automatic push(input int k, input logic [63:0] rdata, input logic [4:0] rd, input logic mis);
      exp_t e;
      e.inst  = k;
      e.rdata = rdata;
      e.rd    = rd;
      e.mis   = mis;
      sb.push_back(e);
   endtask

   // Issue one request with out_ready high and check the memory-port
   // activity and response latency.
   task automatic run_req(input string tag, input int k, input int lat,
                          input logic [63:0] addr, input logic wen,
                          input logic [1:0] size, input logic uns,
                          input logic [63:0] wdata, input logic [4:0] rd,
                          input logic [63:0] exp_rdata, input logic exp_mis,
                          input logic [7:0] exp_mask, input logic [63:0] exp_mwdata);
      int ce_cnt, we_cnt, we_cyc, vcyc;
      push(k, exp_rdata, rd, exp_mis);
      @(posedge clk); #1;
      drive(k, addr, wen, size, uns, wdata, rd);
      @(posedge clk); #1;
      in_valid_v[k] = 1'b0;
      ce_cnt = 0; we_cnt = 0; we_cyc = 0; vcyc = 0;
      for (int c = 1; c <= 40 && vcyc == 0; c++) begin
         @(negedge clk);
         if (mem_ce_v[k]) begin
            ce_cnt++;
            chk({tag, "_mem_addr"}, mem_addr_v[k], {addr[63:3], 3'b000});
         end
         if (mem_we_v[k]) begin
            we_cnt++;
            we_cyc = c;
            chk({tag, "_wmask"}, 64'(mem_wmask_v[k]), 64'(exp_mask));
            chk({tag, "_wdata"}, mem_wdata_v[k], exp_mwdata);
         end
         if (out_valid_v[k]) vcyc = c;
      end
      chk({tag, "_latency"}, 64'(vcyc), exp_mis ? 64'd1 : 64'(lat + 1));
      chk({tag, "_ce_cycles"}, 64'(ce_cnt), exp_mis ? 64'd0 : (wen ? 64'd1 : 64'(lat)));
      chk({tag, "_we_cycles"}, 64'(we_cnt), (wen && !exp_mis) ? 64'd1 : 64'd0);
      if (wen && !exp_mis) chk({tag, "_we_cycle_no"}, 64'(we_cyc), 64'(lat));
   endtask

   initial begin
      int vcyc, we_cnt, v_cnt;
      rst_v       = 3'b111;
      in_valid_v  = 3'b000;
      out_ready_v = 3'b111;
      in_addr     = '0;
      in_wen      = 1'b0;
      in_size     = '0;
      in_unsigned = 1'b0;
      in_wdata    = '0;
      in_rd       = '0;
      mem_rdata   = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready_during", 64'(in_ready_v), 64'd0);
      @(posedge clk); #1;
      rst_v = 3'b000;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready_v), 64'h7);
      chk("rst_out_valid", 64'(out_valid_v), 64'd0);
      chk("rst_out_misalign", 64'(out_misalign_v), 64'd0);
      chk("rst_mem_ce", 64'(mem_ce_v), 64'd0);
      for (int k = 0; k < 3; k++) begin
         chk("rst_out_rdata", out_rdata_v[k], 64'd0);
         chk("rst_out_rd", 64'(out_rd_v[k]), 64'd0);
         chk("rst_wmask", 64'(mem_wmask_v[k]), 64'd0);
      end

      // Loads and stores
      mem_rdata = 64'h1122334480556677;
      run_req("lb_signed", 0, 1, 64'h80000003, 1'b0, 2'd0, 1'b0, 64'd0, 5'd1,
              64'hFFFFFFFFFFFFFF80, 1'b0, 8'h00, 64'd0);
      mem_rdata = 64'h8765432100000000;
      run_req("lwu", 0, 1, 64'h80000004, 1'b0, 2'd2, 1'b1, 64'd0, 5'd2,
              64'h0000000087654321, 1'b0, 8'h00, 64'd0);
      run_req("lw", 0, 1, 64'h80000004, 1'b0, 2'd2, 1'b0, 64'd0, 5'd4,
              64'hFFFFFFFF87654321, 1'b0, 8'h00, 64'd0);
      run_req("lhu_lat3", 1, 3, 64'h80000006, 1'b0, 2'd1, 1'b1, 64'd0, 5'd6,
              64'h0000000000008765, 1'b0, 8'h00, 64'd0);
      run_req("lh_lat3", 1, 3, 64'h80000006, 1'b0, 2'd1, 1'b0, 64'd0, 5'd7,
              64'hFFFFFFFFFFFF8765, 1'b0, 8'h00, 64'd0);
      run_req("sh_lat3", 1, 3, 64'h80000006, 1'b1, 2'd1, 1'b0, 64'h000000000000ABCD, 5'd8,
              64'd0, 1'b0, 8'hC0, 64'hABCD000000000000);
      run_req("ld_lat4", 2, 4, 64'h80000008, 1'b0, 2'd3, 1'b0, 64'd0, 5'd10,
              64'h8765432100000000, 1'b0, 8'h00, 64'd0);
      run_req("lw_misalign", 0, 1, 64'h80000002, 1'b0, 2'd2, 1'b0, 64'd0, 5'd17,
              64'd0, 1'b1, 8'h00, 64'd0);
      run_req("sd_misalign", 2, 4, 64'h80000004, 1'b1, 2'd3, 1'b0, 64'hDEADBEEF, 5'd18,
              64'd0, 1'b1, 8'h00, 64'd0);

      // Backpressure: response held three cycles, a second request waits
      mem_rdata = 64'h1122334480556677;
      out_ready_v[0] = 1'b0;
      push(0, 64'h66, 5'd9, 1'b0);
      @(posedge clk); #1;
      drive(0, 64'h80000001, 1'b0, 2'd0, 1'b1, 64'd0, 5'd9);
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      vcyc = 0;
      for (int c = 1; c <= 40 && vcyc == 0; c++) begin
         @(negedge clk);
         if (out_valid_v[0]) vcyc = c;
      end
      chk("bp_latency", 64'(vcyc), 64'd2);
      for (int h = 0; h < 3; h++) begin
         if (h == 1) begin
            @(posedge clk); #1;
            push(0, 64'h77, 5'd3, 1'b0);
            drive(0, 64'h80000000, 1'b0, 2'd0, 1'b0, 64'd0, 5'd3);
            @(negedge clk);
         end else if (h == 2) begin
            @(negedge clk);
         end
         chk("bp_out_valid", 64'(out_valid_v[0]), 64'd1);
         chk("bp_out_rdata", out_rdata_v[0], 64'h66);
         chk("bp_out_rd", 64'(out_rd_v[0]), 64'd9);
         chk("bp_in_ready", 64'(in_ready_v[0]), 64'd0);
      end
      @(posedge clk); #1;
      out_ready_v[0] = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_release", 64'(in_ready_v[0]), 64'd0);
      @(negedge clk);
      chk("bp_in_ready_after", 64'(in_ready_v[0]), 64'd1);
      @(posedge clk); #1;
      in_valid_v[0] = 1'b0;
      vcyc = 0;
      for (int c = 1; c <= 40 && vcyc == 0; c++) begin
         @(negedge clk);
         if (out_valid_v[0]) vcyc = c;
      end
      chk("bp_second_latency", 64'(vcyc), 64'd2);
      @(posedge clk); #1;

      // Reset during the second access cycle of a store
      drive(2, 64'h80000008, 1'b1, 2'd3, 1'b0, 64'h0123456789ABCDEF, 5'd1);
      @(posedge clk); #1;
      in_valid_v[2] = 1'b0;
      @(negedge clk);
      chk("rstmid_we_c1", 64'(mem_we_v[2]), 64'd0);
      @(posedge clk); #1;
      rst_v[2] = 1'b1;
      @(negedge clk);
      chk("rstmid_we_c2", 64'(mem_we_v[2]), 64'd0);
      chk("rstmid_in_ready_in_rst", 64'(in_ready_v[2]), 64'd0);
      @(posedge clk); #1;
      rst_v[2] = 1'b0;
      @(negedge clk);
      chk("rstmid_in_ready", 64'(in_ready_v[2]), 64'd1);
      chk("rstmid_mem_ce", 64'(mem_ce_v[2]), 64'd0);
      we_cnt = 0; v_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (mem_we_v[2]) we_cnt++;
         if (out_valid_v[2]) v_cnt++;
      end
      chk("rstmid_no_we", 64'(we_cnt), 64'd0);
      chk("rstmid_no_resp", 64'(v_cnt), 64'd0);

      repeat (2) @(posedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting directly upstream of the DPI-backed data memory stage. Consumes one memory request at a time from the execute stage over a valid/ready handshake.
- Aligns the request to the 8-byte memory word, builds the byte write mask and shifted write data, and drives the memory port for a programmable number of cycles.
- Extracts and sign/zero-extends load data, then returns the result to writeback over a second valid/ready handshake.
- Detects misaligned accesses and reports them without touching memory.

Parameters:
- ACCESS_LAT, 1, cycles the memory port is held per access; legal range 1..15; 0 is illegal.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid from execute
- in_ready  output  1  request accepted when in_valid&&in_ready
- in_addr  input  64  byte address
- in_wen  input  1  1=store, 0=load
- in_size  input  2  0=byte, 1=half, 2=word, 3=dword
- in_unsigned  input  1  load zero-extends when 1
- in_wdata  input  64  store data, right-justified
- in_rd  input  5  destination tag, passed through
- out_valid  output  1  response valid to writeback
- out_ready  input  1  writeback accepts response
- out_rdata  output  64  extended load data; 0 for stores and misaligned accesses
- out_rd  output  5  tag of the response
- out_misalign  output  1  response is a misaligned-access fault
- mem_addr  output  64  8-byte-aligned address to memory
- mem_ce  output  1  memory chip enable
- mem_we  output  1  memory write enable
- mem_wdata  output  64  lane-shifted write data
- mem_wmask  output  8  byte lane mask
- mem_rdata  input  64  combinational read data from memory

Behaviour:
- States: IDLE, ACCESS, RESP. Reset forces IDLE and clears counter, out_valid, out_misalign, out_rdata, out_rd, and all request registers.
- mem_* outputs are combinational from state plus request registers. In IDLE and RESP: mem_ce=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- in_ready = (state==IDLE) && !rst.
- IDLE:
  - On handshake, latch addr, wen, size, unsigned, wdata, rd.
  - Misaligned means the size-dependent low address bits are nonzero (addr[0] for half, addr[1:0] for word, addr[2:0] for dword). On misaligned: next state RESP with out_misalign=1 and out_rdata=0.
  - Otherwise next state ACCESS, counter=ACCESS_LAT-1.
- ACCESS:
  - mem_addr = {addr[63:3],3'b000}; off = addr[2:0].
  - mem_wmask = ({1,3,15,255}[size] << off), 8 bits.
  - mem_wdata = wdata << (8*off), truncated to 64 bits; bytes beyond size are don't-care but masked off.
  - Loads: mem_ce=1 every ACCESS cycle, mem_we=0.
  - Stores: mem_ce=mem_we=1 only in the final ACCESS cycle (counter==0), so exactly one write strobe per store.
  - Counter decrements each cycle. When counter==0: for loads, register (mem_rdata >> 8*off) truncated to size and then sign- or zero-extended into out_rdata; for stores, out_rdata=0. Next state RESP.
- RESP:
  - out_valid=1; out_rdata, out_rd and out_misalign are held stable while out_ready=0.
  - On out_ready, next state IDLE and out_valid=0. No new request is accepted in the same cycle, so the minimum initiation interval is ACCESS_LAT+2 cycles.
- Latency:
  - Aligned request accepted at edge T: ACCESS occupies T..T+ACCESS_LAT-1 and out_valid rises after edge T+ACCESS_LAT.
  - Misaligned request: out_valid rises on the cycle after acceptance.
- Reset mid-operation: the pending request is dropped and no response is produced. Because the store strobe is on the last cycle only, a reset before that cycle leaves memory unmodified. mem_ce is 0 from the cycle after the reset edge.
- Inputs other than in_valid are ignored outside IDLE. out_ready is ignored outside RESP.

Test Plan:
- ACCESS_LAT=1, signed byte load at addr 0x80000003, mem_rdata=0x1122334480556677 -> mem_addr=0x80000000, mem_ce=1 for 1 cycle, mem_we=0; out_rdata=0xFFFFFFFFFFFFFF80, out_valid one cycle after access.
- Unsigned word load at 0x80000004, mem_rdata=0x8765432100000000 -> out_rdata=0x0000000087654321; the same access with in_unsigned=0 -> 0xFFFFFFFF87654321.
- Half store at 0x80000006, in_wdata=0x000000000000ABCD, ACCESS_LAT=3 -> mem_wmask=0xC0, mem_wdata=0xABCD000000000000; mem_we high in exactly one cycle (the 3rd); out_rdata=0.
- Word load at 0x80000002 -> mem_ce never asserted; out_misalign=1, out_rdata=0, out_valid on the cycle after acceptance; in_rd tag 5'd17 returned on out_rd.
- Backpressure: hold out_ready=0 for 3 cycles in RESP -> out_valid, out_rdata and out_rd stable; in_ready=0 throughout; a second in_valid is not accepted until the cycle after out_ready=1.
- ACCESS_LAT=4, dword store at 0x80000008, rst asserted during the 2nd ACCESS cycle -> mem_we never asserted, no out_valid; in_ready=1 the cycle after rst deasserts.
